serializer_fifo: RTL and testbench
==================================

# serializer_fifo

Buffered, parametrised parallel-to-serial converter for streaming words of variable length onto a 1-bit serial link. Up to FIFO_DEPTH words are queued behind the active shift register, and words are emitted back-to-back with no idle cycle between them. Bit order is selectable. Words shorter than MIN_LEN are dropped and flagged. It sits between a word-wide producer using a valid/ready handshake and a serial line consumer.

## Interface
- DATA_BUS_WIDTH, 16, parallel word width; must equal 2**DATA_MOD_WIDTH.
- DATA_MOD_WIDTH, 4, width of the length field.
- FIFO_DEPTH, 2, words queued behind the shifter; ≥1.
- MIN_LEN, 3, shortest legal word length in bits; 1..DATA_BUS_WIDTH.
- LSB_FIRST, 0, bit order: 0 = MSB first, 1 = LSB first.
- clk_i  in  1  clock; all logic is on the rising edge.
- arst_i  in  1  reset, asynchronous and active-high.
- data_i  in  DATA_BUS_WIDTH  parallel word.
- data_mod_i  in  DATA_MOD_WIDTH  word length; 0 means DATA_BUS_WIDTH.
- data_val_i  in  1  word valid.
- ready_o  out  1  block can accept a word this cycle.
- ser_data_o  out  1  serial bit; 0 when ser_data_val_o=0.
- ser_data_val_o  out  1  serial bit valid.
- ser_sop_o  out  1  first bit of a word.
- ser_eop_o  out  1  last bit of a word.
- busy_o  out  1  shifter active or FIFO non-empty.
- drop_o  out  1  one-cycle pulse: an accepted word was discarded.

## Operation
- Accept: a word is accepted on a rising edge where data_val_i=1 and ready_o=1. With ready_o=0, inputs are ignored; the producer holds them.
- Length: len = (data_mod_i==0) ? DATA_BUS_WIDTH : data_mod_i, computed with DATA_MOD_WIDTH+1 bits.
- Drop:
  - If len < MIN_LEN, the word is not stored.
  - drop_o=1 for the cycle after the accept edge.
  - FIFO and shifter are unaffected.
- Storage: each legal word is stored with its len.
  - If the shifter is idle or finishing, the word loads the shifter directly (bypass).
  - Otherwise it is written to the FIFO.
- ready_o = !(FIFO full). The block therefore holds at most FIFO_DEPTH+1 legal words.
- Bit selection:
  - LSB_FIRST=0: sends data[W-1] down to data[W-len].
  - LSB_FIRST=1: sends data[0] up to data[len-1].
  - Bit counter width is DATA_MOD_WIDTH+1.
- State machine:
  - IDLE → SHIFT when a legal word is available (bypass input or FIFO head).
  - SHIFT → SHIFT on the last bit if another legal word is available; it loads with no gap.
  - SHIFT → IDLE on the last bit otherwise.
- Outputs:
  - ser_data_val_o=1 exactly in SHIFT.
  - ser_sop_o on the word's first bit; ser_eop_o on its last bit.
  - Both are 1 together only when len=1 (legal only if MIN_LEN=1).
- busy_o = (state==SHIFT) || FIFO non-empty.

## Timing
- Reset values:
  - ser_data_o, ser_data_val_o, ser_sop_o, ser_eop_o, busy_o, drop_o: 0.
  - ready_o: 0 while arst_i=1 and for the first cycle after deassertion; 1 thereafter.
- Latency: a word accepted at edge t while IDLE with FIFO empty shows its first bit in cycle t+1 (registered outputs, one cycle after the accept edge).
- Throughput: a word of len bits occupies exactly len consecutive valid cycles. The next queued word starts on the following cycle, giving 100% line utilisation while words are queued.
- Simultaneous accept and FIFO pop: legal.
  - With the FIFO full, ready_o stays 0 for that cycle; no same-cycle pass-through of the full condition.
  - FIFO order is strict; the bypass is used only when the FIFO is empty.
- Accept on the last-bit cycle of the current word, FIFO empty: the new word's first bit follows the current eop with no gap.
- Dropped word accepted while SHIFT: the serial stream is not disturbed.
- Reset mid-word:
  - Outputs go to reset values immediately (asynchronous).
  - FIFO and shifter contents are discarded; no partial word resumes.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty come from an occupancy count 0..FIFO_DEPTH, not from pointer equality.

## Test plan
- Defaults, single word:
  - Stimulus: data_i=16'hA5C3, data_mod_i=0, idle.
  - Required: 16 valid bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 starting at t+1.
  - sop on bit 0, eop on bit 15, busy_o falls after eop.
- Back-to-back:
  - Stimulus: three words, data_mod_i=5, 8, 0, presented on consecutive cycles.
  - Required: 29 contiguous valid cycles and 3 sop/eop pairs.
  - ready_o=0 exactly when 1 word is shifting and 2 are queued.
- Drop:
  - Stimulus: data_mod_i=2 accepted while idle.
  - Required: drop_o=1 for one cycle; ser_data_val_o stays 0; busy_o stays 0.
  - Repeat while shifting: the stream is unchanged.
- LSB_FIRST=1:
  - Stimulus: data_i=16'h000B, data_mod_i=4.
  - Required: bits 1,1,0,1 with eop on the 4th.
- Backpressure:
  - Stimulus: data_val_i held high for 6 words with FIFO_DEPTH=2.
  - Required: no word lost or duplicated; output order equals input order.
- Reset mid-word:
  - Stimulus: assert arst_i at bit 7 of a 16-bit word with one word queued.
  - Required: outputs drop to 0 asynchronously; after release, ready_o=1 after one cycle and no residual bits are emitted.

Source files
------------

// File: rtl/serializer_fifo.sv
// Buffered parallel-to-serial converter: variable-length words queue in a small FIFO
// behind a shift register and leave back-to-back on a 1-bit link.
module serializer_fifo #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4,
    parameter int FIFO_DEPTH     = 2,
    parameter int MIN_LEN        = 3,
    parameter bit LSB_FIRST      = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic [DATA_BUS_WIDTH-1:0] data_i,
    input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
    input  logic                      data_val_i,
    output logic                      ready_o,
    output logic                      ser_data_o,
    output logic                      ser_data_val_o,
    output logic                      ser_sop_o,
    output logic                      ser_eop_o,
    output logic                      busy_o,
    output logic                      drop_o
);
    localparam int W  = DATA_BUS_WIDTH;
    localparam int LW = DATA_MOD_WIDTH + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    state_t state_q, state_d;

    logic [W-1:0]  sh_q, sh_d;
    logic [LW-1:0] len_q, len_d, idx_q, idx_d;
    logic [W-1:0]  fifo_data [FIFO_DEPTH];
    logic [LW-1:0] fifo_len  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, drop_q;

    logic [LW-1:0] len_in;
    logic          accept, legal, last_bit, shifter_free, fifo_empty, push, pop;

    // Handshake: a word transfers on a rising edge where data_val_i && ready_o;
    // while ready_o is low the producer holds data_i/data_mod_i/data_val_i stable.
    assign accept       = data_val_i && ready_q;
    assign len_in       = (data_mod_i == '0) ? LW'(W) : {1'b0, data_mod_i};
    assign legal        = (len_in >= LW'(MIN_LEN));
    assign fifo_empty   = (cnt_q == '0);
    assign last_bit     = (state_q == ST_SHIFT) && (idx_q == len_q - LW'(1));
    assign shifter_free = (state_q == ST_IDLE) || last_bit;

    // Strict order: the input bypasses the FIFO only when nothing is queued.
    assign push = accept && legal && !(shifter_free && fifo_empty);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        len_d   = len_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        if (shifter_free) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = ST_SHIFT;
                sh_d    = fifo_data[rd_ptr_q];
                len_d   = fifo_len[rd_ptr_q];
                idx_d   = '0;
            end else if (accept && legal) begin
                state_d = ST_SHIFT;
                sh_d    = data_i;
                len_d   = len_in;
                idx_d   = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
            idx_d = idx_q + LW'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            sh_q     <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            // Registered from the next occupancy, so a full FIFO never passes through.
            ready_q <= (cnt_d != CW'(FIFO_DEPTH));
            drop_q  <= accept && !legal;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= data_i;
            fifo_len[wr_ptr_q]  <= len_in;
        end
    end

    assign ser_data_val_o = (state_q == ST_SHIFT);
    assign ser_data_o     = ser_data_val_o && (LSB_FIRST ? sh_q[0] : sh_q[W-1]);
    assign ser_sop_o      = ser_data_val_o && (idx_q == '0);
    assign ser_eop_o      = last_bit;
    assign busy_o         = ser_data_val_o || !fifo_empty;
    assign ready_o        = ready_q;
    assign drop_o         = drop_q;
endmodule

// File: tb/tb_serializer_fifo.sv
// Bench for serializer_fifo: directed and random words checked against a bit-stream
// model built from word lengths and bit-order rules; an LSB-first copy gets directed checks.
module tb_serializer_fifo;
    localparam int W       = 16;
    localparam int MW      = 4;
    localparam int DEPTH   = 2;
    localparam int MIN_LEN = 3;

    logic          clk = 1'b0;
    logic          arst;
    logic [W-1:0]  data_i;
    logic [MW-1:0] data_mod_i;
    logic          data_val_i;
    logic ready, ser_data, ser_val, ser_sop, ser_eop, busy, drop;
    logic l_ready, l_data, l_val, l_sop, l_eop, l_busy, l_drop;

    always #5 clk = ~clk;

    serializer_fifo #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW), .FIFO_DEPTH(DEPTH),
                      .MIN_LEN(MIN_LEN), .LSB_FIRST(1'b0)) dut (
        .clk_i(clk), .arst_i(arst), .data_i(data_i), .data_mod_i(data_mod_i),
        .data_val_i(data_val_i), .ready_o(ready), .ser_data_o(ser_data),
        .ser_data_val_o(ser_val), .ser_sop_o(ser_sop), .ser_eop_o(ser_eop),
        .busy_o(busy), .drop_o(drop)
    );

    serializer_fifo #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW), .FIFO_DEPTH(DEPTH),
                      .MIN_LEN(MIN_LEN), .LSB_FIRST(1'b1)) dut_lsb (
        .clk_i(clk), .arst_i(arst), .data_i(data_i), .data_mod_i(data_mod_i),
        .data_val_i(data_val_i), .ready_o(l_ready), .ser_data_o(l_data),
        .ser_data_val_o(l_val), .ser_sop_o(l_sop), .ser_eop_o(l_eop),
        .busy_o(l_busy), .drop_o(l_drop)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_age = 0;
    logic [2:0] exp_q[$];   // {sop, eop, bit} per expected serial cycle
    int acc_q[$];           // cycle at which each legal word enters the block
    int drop_q[$];          // cycle at which drop_o must be high
    int held = 0, run = 0, last_run = 0, sop_cnt = 0, eop_cnt = 0;
    logic [2:0] mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge arst) begin
        if (arst) rst_age <= 0;
        else if (rst_age < 3) rst_age <= rst_age + 1;
    end

    // Monitor: compares every cycle against the model away from the active edge.
    always @(negedge clk) begin
        if (arst) begin
            run = 0;
        end else begin
            while (acc_q.size() > 0 && acc_q[0] <= cyc) begin
                void'(acc_q.pop_front());
                held++;
            end
            if (drop_q.size() > 0 && drop_q[0] == cyc) begin
                void'(drop_q.pop_front());
                check("drop", drop, 1);
            end else begin
                check("drop", drop, 0);
            end
            check("ready", ready, (rst_age >= 1) && (held < DEPTH + 1));
            check("busy", busy, held > 0);
            if (ser_val) begin
                if (exp_q.size() == 0) begin
                    check("extra_bit", ser_val, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bit", {ser_sop, ser_eop, ser_data}, mon_e);
                    if (mon_e[1]) held--;
                end
                if (ser_sop) sop_cnt++;
                if (ser_eop) eop_cnt++;
                run++;
            end else begin
                check("idle_out", {ser_sop, ser_eop, ser_data}, 0);
                if (run > 0) last_run = run;
                run = 0;
            end
        end
    end

    // Called at the negedge before the accepting edge.
    task automatic model_accept(input logic [W-1:0] d, input logic [MW-1:0] m);
        int len;
        len = (m == 0) ? W : int'(m);
        if (len < MIN_LEN) begin
            drop_q.push_back(cyc + 1);
        end else begin
            acc_q.push_back(cyc + 1);
            for (int i = 0; i < len; i++)
                exp_q.push_back({i == 0, i == len - 1, d[W-1-i]});
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [MW-1:0] m);
        int waited;
        waited = 0;
        data_i = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) check("accept_timeout", ready, 1);
        else model_accept(d, m);
        @(negedge clk);
        data_val_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((held > 0 || exp_q.size() > 0 || acc_q.size() > 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        acc_q.delete();
        drop_q.delete();
        held = 0;
    endtask

    initial begin
        int s0, e0;
        logic [MW-1:0] m;
        arst = 1'b1;
        data_i = '0;
        data_mod_i = '0;
        data_val_i = 1'b0;
        #1;
        check("rst_outs", {ser_data, ser_val, ser_sop, ser_eop, busy, drop}, 0);
        check("rst_ready", ready, 0);
        repeat (3) @(negedge clk);
        arst = 1'b0;
        check("ready_first_cycle", ready, 0);
        @(negedge clk);
        check("ready_after_one", ready, 1);
        @(negedge clk);

        // Single full-width word, MSB first
        send_word(16'hA5C3, 4'd0);
        wait_idle();
        check("single_run", last_run, 16);

        // Three words on consecutive cycles
        s0 = sop_cnt;
        e0 = eop_cnt;
        send_word(W'($urandom), 4'd5);
        send_word(W'($urandom), 4'd8);
        send_word(W'($urandom), 4'd0);
        check("b2b_full", ready, 0);
        wait_idle();
        check("b2b_run", last_run, 29);
        check("b2b_sop", sop_cnt - s0, 3);
        check("b2b_eop", eop_cnt - e0, 3);

        // Drops while idle and while shifting
        send_word(W'($urandom), 4'd2);
        repeat (3) @(negedge clk);
        send_word(W'($urandom), 4'd0);
        repeat (3) @(negedge clk);
        send_word(W'($urandom), 4'd1);
        send_word(W'($urandom), 4'd2);
        wait_idle();
        check("drop_run", last_run, 16);

        // LSB-first instance
        send_word(16'h000B, 4'd4);
        check("lsb_b0", {l_val, l_sop, l_eop, l_data}, 4'b1101);
        @(negedge clk);
        check("lsb_b1", {l_val, l_sop, l_eop, l_data}, 4'b1001);
        @(negedge clk);
        check("lsb_b2", {l_val, l_sop, l_eop, l_data}, 4'b1000);
        @(negedge clk);
        check("lsb_b3", {l_val, l_sop, l_eop, l_data}, 4'b1011);
        @(negedge clk);
        check("lsb_end", {l_val, l_sop, l_eop, l_data}, 4'b0000);
        wait_idle();

        // Backpressure: data_val_i stays high across six legal words
        for (int i = 0; i < 6; i++) begin
            m = MW'($urandom_range(3, 16));
            send_word(W'($urandom), m);
        end
        wait_idle();

        // Random words, lengths and gaps
        for (int i = 0; i < 60; i++) begin
            send_word(W'($urandom), MW'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset at bit 7 of a 16-bit word with one word queued
        send_word(W'($urandom), 4'd0);
        send_word(W'($urandom), 4'd0);
        repeat (6) @(negedge clk);
        check("pre_rst_bit7", {ser_val, ser_sop, ser_eop}, 3'b100);
        #2;
        arst = 1'b1;
        clear_model();
        #1;
        check("async_rst_outs", {ser_data, ser_val, ser_sop, ser_eop, busy, drop}, 0);
        check("async_rst_ready", ready, 0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        check("rel_ready_first", ready, 0);
        @(negedge clk);
        check("rel_ready_after", ready, 1);
        repeat (25) @(negedge clk);
        check("no_residual", busy, 0);

        // Normal operation resumes after reset
        send_word(W'($urandom), 4'd7);
        wait_idle();
        check("post_rst_run", last_run, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
